pipeline_hazard_controller: RTL

- Sequences stalls, bubbles, flushes and freezes for the 5-stage pipeline. Its outputs drive the IF stage, the IF/ID register, the ID controller's hazard_detected input, and the ID/EXE, EXE/MEM and MEM/WB registers.
- Detects RAW and load-use hazards against ID sources, handles taken-branch flush, and holds the pipeline through multi-cycle data-memory accesses via a request/ready handshake.
- Includes a memory watchdog.

---
 rtl/pipeline_hazard_controller_pkg.sv | 25 ++
 rtl/pipeline_hazard_controller_if.sv | 48 ++++
 rtl/pipeline_hazard_controller_hazard_compare.sv | 36 +++
 rtl/pipeline_hazard_controller.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Supplies REG_FILE_ADDR_LEN only when the wider codebase has not defined it.
// Also supplies HZ_STATE_LEN and the HZ_RUN, HZ_MEM_WAIT and HZ_ERR state encodings.
`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 5
`endif
`ifndef HZ_STATE_LEN
`define HZ_STATE_LEN 2
`define HZ_RUN 2'd0
`define HZ_MEM_WAIT 2'd1
`define HZ_ERR 2'd2
`endif

package pipeline_hazard_controller_pkg;
  localparam int REG_W   = `REG_FILE_ADDR_LEN;
  localparam int STATE_W = `HZ_STATE_LEN;
  // Wide enough for the largest legal MEM_TIMEOUT (65535).
  localparam int WAIT_W  = 16;

  typedef enum logic [STATE_W-1:0] {
    HZ_S_RUN      = `HZ_RUN,
    HZ_S_MEM_WAIT = `HZ_MEM_WAIT,
    HZ_S_ERR      = `HZ_ERR
  } hz_state_e;
endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle between the pipeline stages (master) and the hazard controller (slave).
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 32
);
  import pipeline_hazard_controller_pkg::*;

  logic               forward_en;
  logic [REG_W-1:0]   src1;
  logic [REG_W-1:0]   src2;
  logic               is_imm;
  logic               st_or_bne;
  logic               br_taken;
  logic [REG_W-1:0]   exe_dest;
  logic               exe_wb_en;
  logic               exe_mem_r_en;
  logic [REG_W-1:0]   mem_dest;
  logic               mem_wb_en;
  logic               mem_req;
  logic               mem_ready;
  logic               hazard_detected;
  logic               pc_freeze;
  logic               if_id_freeze;
  logic               if_id_flush;
  logic               pipe_freeze;
  logic               mem_timeout_err;
  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;
  logic [CNT_W-1:0]   memwait_cnt;

  modport master (
    output forward_en, src1, src2, is_imm, st_or_bne, br_taken,
           exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
           mem_req, mem_ready,
    input  hazard_detected, pc_freeze, if_id_freeze, if_id_flush,
           pipe_freeze, mem_timeout_err, state,
           stall_cnt, flush_cnt, memwait_cnt
  );

  modport slave (
    input  forward_en, src1, src2, is_imm, st_or_bne, br_taken,
           exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
           mem_req, mem_ready,
    output hazard_detected, pc_freeze, if_id_freeze, if_id_flush,
           pipe_freeze, mem_timeout_err, state,
           stall_cnt, flush_cnt, memwait_cnt
  );
endinterface

// File: rtl/pipeline_hazard_controller_hazard_compare.sv
// RAW / load-use detection of the ID sources against the EXE and MEM
// destinations. With forwarding only a load in EXE can stall; without it
// any writer in EXE or MEM stalls. Register 0 never hazards.
module hazard_compare
  import pipeline_hazard_controller_pkg::*;
(
  input  logic             forward_en,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             is_imm,
  input  logic             st_or_bne,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  output logic             raw_hz
);
  logic use1;
  logic use2;
  logic exe_hit;
  logic mem_hit;

  // Match used, non-zero sources against each in-flight destination.
  always_comb begin
    use1    = (src1 != '0);
    use2    = (!is_imm || st_or_bne) && (src2 != '0);
    exe_hit = (use1 && (src1 == exe_dest)) || (use2 && (src2 == exe_dest));
    mem_hit = (use1 && (src1 == mem_dest)) || (use2 && (src2 == mem_dest));
    if (forward_en) begin
      raw_hz = exe_mem_r_en && exe_wb_en && exe_hit;
    end else begin
      raw_hz = (exe_wb_en && exe_hit) || (mem_wb_en && mem_hit);
    end
  end
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: stall/bubble/flush/freeze sequencing, memory
// wait FSM with a sticky watchdog. Define HAZARD_PERF_CNT_EN to build the
// saturating stall/flush/memwait counters; otherwise those ports read 0.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_controller_if.slave bus
);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  hz_state_e         state_q;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_inc;
  logic              err_q;
  logic              raw_hz;
  logic              mw;
  logic              frz;
  logic              hz_o;
  logic              stall_o;
  logic              flush_o;
  logic              freeze_o;

  function automatic logic [WAIT_W-1:0] wait_sat_inc(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hazard_compare u_cmp (
    .forward_en   (bus.forward_en),
    .src1         (bus.src1),
    .src2         (bus.src2),
    .is_imm       (bus.is_imm),
    .st_or_bne    (bus.st_or_bne),
    .exe_dest     (bus.exe_dest),
    .exe_wb_en    (bus.exe_wb_en),
    .exe_mem_r_en (bus.exe_mem_r_en),
    .mem_dest     (bus.mem_dest),
    .mem_wb_en    (bus.mem_wb_en),
    .raw_hz       (raw_hz)
  );

  assign mw       = bus.mem_req && !bus.mem_ready;
  assign frz      = mw || ((state_q != HZ_S_RUN) && !bus.mem_ready);
  assign wait_inc = wait_sat_inc(wait_q);

  // Outputs are held low while reset is asserted, even with live inputs.
  assign freeze_o = rst && frz;
  assign hz_o     = rst && raw_hz && !frz;
  assign stall_o  = rst && (frz || raw_hz);
  assign flush_o  = rst && bus.br_taken && !raw_hz && !frz;

  assign bus.pipe_freeze     = freeze_o;
  assign bus.hazard_detected = hz_o;
  assign bus.pc_freeze       = stall_o;
  assign bus.if_id_freeze    = stall_o;
  assign bus.if_id_flush     = flush_o;
  assign bus.mem_timeout_err = err_q;
  assign bus.state           = state_q;

  // Memory-wait FSM with wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HZ_S_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        HZ_S_RUN: begin
          if (mw) begin
            state_q <= HZ_S_MEM_WAIT;
            wait_q  <= WAIT_W'(1);
          end
        end
        HZ_S_MEM_WAIT: begin
          // A ready on the threshold cycle completes the access; no error.
          if (bus.mem_ready) begin
            state_q <= HZ_S_RUN;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_inc;
            if (wait_inc >= TIMEOUT_V) begin
              state_q <= HZ_S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        HZ_S_ERR: begin
          if (bus.mem_ready) begin
            state_q <= HZ_S_RUN;
            wait_q  <= '0;
          end
        end
        default: begin
          state_q <= HZ_S_RUN;
          wait_q  <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic [CNT_W-1:0] memwait_q;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q   <= '0;
      flush_q   <= '0;
      memwait_q <= '0;
    end else begin
      if (hz_o)     stall_q   <= cnt_sat_inc(stall_q);
      if (flush_o)  flush_q   <= cnt_sat_inc(flush_q);
      if (freeze_o) memwait_q <= cnt_sat_inc(memwait_q);
    end
  end

  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;
  assign bus.memwait_cnt = memwait_q;
`else
  assign bus.stall_cnt   = '0;
  assign bus.flush_cnt   = '0;
  assign bus.memwait_cnt = '0;
`endif
endmodule
